// File: rtl/puf_measure_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : puf_measure_ctrl                                           |
// | Description : Ring-oscillator PUF measurement sequencer. For each        |
// |               challenge index it selects an oscillator pair, clears the  |
// |               pair counters, gates them for a fixed window, lets them    |
// |               settle, then compares the two counts into one response     |
// |               bit. The finished word is offered with valid/ack.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports:
//   clk, rst_n        : system clock, asynchronous active-low reset
//   start             : level, sampled in IDLE only; begins a measurement
//   abort             : synchronous abort, highest priority, any state
//   cnt_a, cnt_b      : counts of oscillators A/B of the selected pair
//   resp_ack          : consumer accepts resp (honoured in DONE only)
//   sel               : challenge index driving the oscillator-pair mux
//   cnt_clr, cnt_en   : clear / count-enable to both counters
//   busy              : high in every state except IDLE
//   resp, resp_valid  : response word (bit i from challenge i) and its valid
//   tie_seen          : sticky flag, some bit had cnt_a == cnt_b
module puf_measure_ctrl #(
  parameter int CNT_W      = 32,
  parameter int WINDOW     = 1048575,
  parameter int SETTLE     = 4,
  parameter int CLR_CYCLES = 2,
  parameter int NUM_BITS   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CNT_W-1:0]            cnt_a,
  input  logic [CNT_W-1:0]            cnt_b,
  input  logic                        resp_ack,
  output logic [$clog2(NUM_BITS)-1:0] sel,
  output logic                        cnt_clr,
  output logic                        cnt_en,
  output logic                        busy,
  output logic [NUM_BITS-1:0]         resp,
  output logic                        resp_valid,
  output logic                        tie_seen
);

  localparam int IDX_W   = $clog2(NUM_BITS);
  localparam int MAX_CYC = (WINDOW > SETTLE)
                           ? ((WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES)
                           : ((SETTLE > CLR_CYCLES) ? SETTLE : CLR_CYCLES);
  // Timer counts down from N-1 to 0, so N itself never has to be stored and
  // WINDOW = 2^n-1 fits without wrapping.
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);
  localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  // S_LOAD is a one-cycle arming state between the accepted start and the
  // first clear phase; it initialises the per-measurement registers.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CLEAR   = 3'd2,
    S_GATE    = 3'd3,
    S_SETTLE  = 3'd4,
    S_COMPARE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] resp_q, resp_d;
  logic                tie_q, tie_d;
  logic                cnt_clr_q, cnt_clr_d;
  logic                cnt_en_q, cnt_en_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    resp_d  = resp_q;
    tie_d   = tie_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
          resp_d  = '0;
          tie_d   = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_CLEAR;
        timer_d = CLR_LOAD;
      end
      S_CLEAR: begin
        if (timer_q == '0) begin
          state_d = S_GATE;
          timer_d = WIN_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GATE: begin
        if (timer_q == '0) begin
          state_d = S_SETTLE;
          timer_d = SET_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_SETTLE: begin
        if (timer_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_COMPARE: begin
        resp_d[idx_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) begin
          tie_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CLEAR;
          timer_d = CLR_LOAD;
        end
      end
      S_DONE: begin
        // sel (= idx) holds its last value here; it returns to 0 with IDLE.
        if (resp_ack) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      timer_d = '0;
      idx_d   = '0;
      resp_d  = '0;
      tie_d   = 1'b0;
    end

    // Strobes are decoded from the next state so the registered outputs
    // line up exactly with the state they describe.
    cnt_clr_d = (state_d == S_CLEAR);
    cnt_en_d  = (state_d == S_GATE);
    busy_d    = (state_d != S_IDLE);
    valid_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      idx_q     <= '0;
      resp_q    <= '0;
      tie_q     <= 1'b0;
      cnt_clr_q <= 1'b0;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      idx_q     <= idx_d;
      resp_q    <= resp_d;
      tie_q     <= tie_d;
      cnt_clr_q <= cnt_clr_d;
      cnt_en_q  <= cnt_en_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign sel        = idx_q;
  assign cnt_clr    = cnt_clr_q;
  assign cnt_en     = cnt_en_q;
  assign busy       = busy_q;
  assign resp       = resp_q;
  assign resp_valid = valid_q;
  assign tie_seen   = tie_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_measure_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_puf_measure_ctrl                                        |
// | Description : Directed self-checking bench for puf_measure_ctrl with a   |
// |               response scoreboard fed from per-challenge count tables.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_puf_measure_ctrl;

  localparam int CNT_W      = 32;
  localparam int WINDOW     = 16;
  localparam int SETTLE     = 4;
  localparam int CLR_CYCLES = 2;
  localparam int NUM_BITS   = 4;
  localparam int P          = CLR_CYCLES + WINDOW + SETTLE + 1;
  localparam int LAT        = 1 + NUM_BITS * P;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic                resp_ack = 1'b0;
  logic [CNT_W-1:0]    cnt_a, cnt_b;
  logic [1:0]          sel;
  logic                cnt_clr, cnt_en, busy, resp_valid, tie_seen;
  logic [NUM_BITS-1:0] resp;

  logic [CNT_W-1:0]    a_tab [NUM_BITS];
  logic [CNT_W-1:0]    b_tab [NUM_BITS];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [NUM_BITS-1:0] resp;
    logic                tie;
  } exp_t;
  exp_t sb[$];

  puf_measure_ctrl #(
    .CNT_W(CNT_W), .WINDOW(WINDOW), .SETTLE(SETTLE),
    .CLR_CYCLES(CLR_CYCLES), .NUM_BITS(NUM_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .resp_ack(resp_ack),
    .sel(sel), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .busy(busy),
    .resp(resp), .resp_valid(resp_valid), .tie_seen(tie_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the counter pair: counts are a function of the selected pair.
  assign cnt_a = a_tab[sel];
  assign cnt_b = b_tab[sel];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tables(input logic [CNT_W-1:0] a0, a1, a2, a3,
                            input logic [CNT_W-1:0] b0, b1, b2, b3);
    a_tab[0] = a0; a_tab[1] = a1; a_tab[2] = a2; a_tab[3] = a3;
    b_tab[0] = b0; b_tab[1] = b1; b_tab[2] = b2; b_tab[3] = b3;
  endtask

  // Reference: bit i = unsigned a>b, tie if any pair equal.
  task automatic push_expected;
    exp_t e;
    e = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      e.resp[i] = (a_tab[i] > b_tab[i]);
      if (a_tab[i] == b_tab[i]) e.tie = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic pulse_start(output int t0);
    start = 1'b1;
    tick;
    start = 1'b0;
    t0 = cyc;
  endtask

  // Runs until resp_valid; optionally pulses start in the middle of bit 1's gate.
  task automatic wait_done(input int t0, input bit pulse_mid, input string tag);
    int   n_en, gates, lat;
    bit   prev_en, got, pulsed;
    logic [7:0] sel_seq;
    exp_t e;
    n_en = 0; gates = 0; lat = 0; prev_en = 0; got = 0; pulsed = 0; sel_seq = '0;
    for (int i = 0; i < LAT + 20 && !got; i++) begin
      start = pulse_mid && (gates == 2) && cnt_en && !pulsed;
      if (start) pulsed = 1;
      tick;
      if (cnt_en) n_en++;
      if (cnt_en && !prev_en) begin
        gates++;
        sel_seq = {sel_seq[5:0], sel};
      end
      prev_en = cnt_en;
      if (resp_valid) begin
        got = 1;
        lat = cyc - t0;
      end
    end
    start = 1'b0;
    check({tag, "_valid_seen"}, got, 1);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_en_cycles"}, n_en, NUM_BITS * WINDOW);
    check({tag, "_gates"}, gates, NUM_BITS);
    check({tag, "_sel_seq"}, sel_seq, 8'h1B);
    check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_resp"}, resp, e.resp);
      check({tag, "_tie"}, tie_seen, e.tie);
    end
  endtask

  task automatic do_ack(input string tag);
    resp_ack = 1'b1;
    tick;
    resp_ack = 1'b0;
    check({tag, "_ack_valid"}, resp_valid, 0);
    check({tag, "_ack_busy"}, busy, 0);
  endtask

  initial begin
    int         t0, gates, ingate;
    bit         prev_en, got, stable;
    logic [NUM_BITS-1:0] ref_resp;

    set_tables(32'd100, 32'd50, 32'd7, 32'hFFFF_FFFF,
               32'd90,  32'd60, 32'd7, 32'd0);

    // Reset state
    tick; tick;
    check("reset_outputs", {sel, cnt_clr, cnt_en, busy, resp, resp_valid, tie_seen}, '0);
    rst_n = 1'b1;
    tick;
    check("idle_outputs", {sel, cnt_clr, cnt_en, busy, resp, resp_valid, tie_seen}, '0);

    // Run A: reference tables, stray start during bit 1 gate
    push_expected();
    pulse_start(t0);
    check("a_busy_after_start", busy, 1);
    wait_done(t0, 1'b1, "a");
    check("a_resp_literal", resp, 4'b1001);

    // Hold without ack for 50 cycles
    ref_resp = resp;
    stable = 1;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (!resp_valid || !busy || resp !== ref_resp || sel !== 2'd3) stable = 0;
    end
    check("a_hold_stable", stable, 1);

    // Ack and start together: ack wins, start re-evaluated next cycle
    resp_ack = 1'b1;
    start = 1'b1;
    tick;
    resp_ack = 1'b0;
    check("ackstart_valid", resp_valid, 0);
    check("ackstart_busy", busy, 0);
    check("ackstart_sel", sel, 0);
    check("ackstart_resp_kept", resp, 4'b1001);
    tick;
    start = 1'b0;
    check("restart_busy", busy, 1);

    // Run B: abort on the 5th gate cycle of bit 2
    gates = 0; ingate = 0; prev_en = 0; got = 0;
    for (int i = 0; i < LAT + 20 && !got; i++) begin
      if (cnt_en && !prev_en) gates++;
      if (gates == 3 && cnt_en) ingate++;
      prev_en = cnt_en;
      if (ingate == 5) got = 1;
      else tick;
    end
    check("b_reach_gate2", got, 1);
    check("b_partial_resp", resp, 4'b0001);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check("abort_cnt_en", cnt_en, 0);
    check("abort_resp", resp, 0);
    check("abort_busy", busy, 0);
    check("abort_misc", {sel, cnt_clr, resp_valid, tie_seen}, '0);
    tick;

    // Run C: different pattern, no ties
    set_tables(32'd5, 32'd200, 32'd1, 32'd9,
               32'd6, 32'd100, 32'd0, 32'd3);
    push_expected();
    pulse_start(t0);
    wait_done(t0, 1'b0, "c");
    check("c_resp_literal", resp, 4'b1110);
    do_ack("c");

    // Run D: reset asserted mid-SETTLE of bit 0
    pulse_start(t0);
    prev_en = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick;
      if (prev_en && !cnt_en) got = 1;
      prev_en = cnt_en;
    end
    check("d_reach_settle", got, 1);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("d_async_reset", {sel, cnt_clr, cnt_en, busy, resp, resp_valid, tie_seen}, '0);
    tick; tick;
    rst_n = 1'b1;
    tick;
    check("d_after_release", {busy, resp_valid, resp}, '0);

    // Run E: full measurement after reset, all-ones operands and a tie
    set_tables(32'd0, 32'hFFFF_FFFF, 32'd3, 32'd0,
               32'd1, 32'hFFFF_FFFE, 32'd3, 32'd0);
    push_expected();
    pulse_start(t0);
    wait_done(t0, 1'b0, "e");
    check("e_resp_literal", resp, 4'b0010);
    do_ack("e");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
